nios2vga_cpu_dct_unpacker: RTL and testbench
============================================

Name: nios2vga_cpu_dct_unpacker

Overview:
- Reader for the CPU debug-trace packed buffer: takes a 30-bit packed word plus a 4-bit entry count and emits the 2-bit trace symbols one per cycle.
- Sits between the OCI trace capture (the writer, which packs dct_buffer/dct_count) and the trace drain/JTAG side.
- Valid/ready handshakes on both sides.
- Also handles the end-of-trace flush and reports when draining is finished.

Parameters:
- SYM_W, 2, width of one trace symbol.
- MAX_SYMS, 15, symbols per packed word; buffer width is SYM_W*MAX_SYMS = 30.
- CNT_W, 4, width of the count field; must hold MAX_SYMS.
- TOTAL_W, 16, width of the emitted-symbol counter.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- dct_buffer  input  30  packed symbols; symbol i is at bits [2i+1:2i], LSB first.
- dct_count  input  4  number of valid symbols in dct_buffer (0..15).
- in_valid  input  1  dct_buffer/dct_count valid.
- in_ready  output  1  unpacker accepts the word this cycle.
- out_symbol  output  2  current symbol.
- out_last  output  1  out_symbol is the final symbol of its word.
- out_valid  output  1  out_symbol valid.
- out_ready  input  1  downstream accepts the symbol.
- test_ending  input  1  end-of-trace request, level; latched sticky.
- test_has_ended  output  1  drain complete; held high until reset.
- sym_total  output  16  count of symbols handshaken on the output, wraps modulo 2^16.

Behaviour:
- Reset: synchronous, active-high; a reset mid-word discards the held word. Values after reset:
  - out_valid=0, out_last=0, out_symbol=0
  - in_ready=1
  - test_has_ended=0, sym_total=0
  - internal state IDLE, sticky ending flag cleared
- State machine:
  - IDLE, no word held: in_ready=1 unless the ending flag is set.
  - EMIT, word held: shift register sr[29:0] and remaining count rem[3:0].
  - ENDED: test_has_ended=1, in_ready=0, out_valid=0.
- Accept: a word is accepted on any cycle where in_valid and in_ready are both 1.
  - If dct_count is 0, the word is consumed with no output and the state is unchanged.
  - If dct_count > 0: sr<=dct_buffer, rem<=dct_count, go to EMIT.
  - Latency: out_valid is asserted the cycle after acceptance.
- EMIT outputs: out_valid=1, out_symbol=sr[1:0], out_last=(rem==1).
- Output handshake (out_valid && out_ready): sr<=sr>>2, rem<=rem-1, sym_total<=sym_total+1.
  - When rem reaches 0: return to IDLE, or go to ENDED if the ending flag is set.
- Stall: if out_ready=0, all outputs and sr/rem hold stable.
- Back-to-back: in EMIT, in_ready=1 when rem==1 && out_ready && ending flag clear.
  - A new word is then loaded in the same cycle the last symbol handshakes, so there are no bubbles.
  - A count-0 word accepted that cycle is dropped and the unpacker returns to IDLE.
- Ending flag:
  - Set on the first cycle test_ending=1; from then on in_ready=0.
  - A word accepted in the same cycle test_ending first rises is still accepted and drained.
  - From IDLE with the flag set, move to ENDED on the next cycle.
  - ENDED is left only by reset.
- Width rules: dct_count values above MAX_SYMS are impossible at the default parameters. For other parameters, clamp the count to MAX_SYMS.
- sym_total wraps from 0xFFFF to 0x0000 silently.

Decomposition:
- Shared package nios2vga_dct_pkg:
  - SYM_W, MAX_SYMS, CNT_W, and the derived BUF_W.
  - State enum {IDLE, EMIT, ENDED}.
- Sub-module nios2vga_dct_shift: the sr/rem shift-and-count register with load/shift controls. The top level owns the FSM, the handshakes and sym_total.

Test Plan:
- Reset, then dct_buffer=0x2AAAAAAA (all symbols 2'b10), dct_count=15, out_ready=1 -> 15 consecutive symbols of 2, out_last only on the 15th, sym_total=15, first out_valid one cycle after accept.
- dct_buffer=0x0000001B, count=3 -> symbols 3,2,1 in order, out_last on 1. Second word offered continuously -> accepted on the last-symbol cycle with no idle cycle between words.
- out_ready toggled 1/0 every cycle during a count=4 word -> outputs stable while stalled; exactly 4 handshakes; sym_total +4.
- Word with count=0 -> in_ready stays 1, no out_valid, sym_total unchanged.
- test_ending pulsed mid-word (count=5, after 2 symbols):
  - in_ready drops immediately.
  - The remaining 3 symbols are still emitted.
  - test_has_ended rises the cycle after the last handshake and stays high.
  - A later in_valid is never accepted.
- Reset asserted mid-word -> next cycle out_valid=0, in_ready=1, sym_total=0; the interrupted word is never resumed.

Source files
------------

// File: rtl/nios2vga_dct_pkg.sv
// Shared constants and state encoding for the debug-trace packed-buffer unpacker.
package nios2vga_dct_pkg;

    localparam int SYM_W    = 2;
    localparam int MAX_SYMS = 15;
    localparam int CNT_W    = 4;
    localparam int BUF_W    = SYM_W * MAX_SYMS;
    localparam int TOTAL_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT  = 2'd1,
        ENDED = 2'd2
    } dct_state_e;

endpackage

// File: rtl/nios2vga_dct_shift.sv
// Holds one packed trace word and its remaining symbol count; shifts one symbol out per step.
module nios2vga_dct_shift
    import nios2vga_dct_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               shift,
    input  logic [BUF_W-1:0]   load_buf,
    input  logic [CNT_W-1:0]   load_cnt,
    output logic [SYM_W-1:0]   sym,
    output logic [CNT_W-1:0]   rem
);

    logic [BUF_W-1:0] sr;

    // Payload register carries no reset; rem alone says whether it is meaningful.
    always_ff @(posedge clk) begin
        if (load) begin
            sr <= load_buf;
        end else if (shift) begin
            sr <= sr >> SYM_W;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem <= '0;
        end else if (load) begin
            rem <= load_cnt;
        end else if (shift) begin
            rem <= rem - CNT_W'(1);
        end
    end

    assign sym = sr[SYM_W-1:0];

endmodule

// File: rtl/nios2vga_cpu_dct_unpacker.sv
// Unpacks a 30-bit debug-trace word into 2-bit symbols, one per output handshake,
// with a sticky end-of-trace flush that parks in ENDED once the last word drains.
module nios2vga_cpu_dct_unpacker
    import nios2vga_dct_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [BUF_W-1:0]     dct_buffer,
    input  logic [CNT_W-1:0]     dct_count,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [SYM_W-1:0]     out_symbol,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    input  logic                 test_ending,
    output logic                 test_has_ended,
    output logic [TOTAL_W-1:0]   sym_total
);

    dct_state_e         state, state_next;
    logic               ending_flag;
    logic               load, shift, hs_out;
    logic [CNT_W-1:0]   cnt_in;
    logic [CNT_W-1:0]   rem;
    logic [SYM_W-1:0]   sym;

    // Widened compare keeps the clamp meaningful for any CNT_W/MAX_SYMS pairing.
    assign cnt_in = ({1'b0, dct_count} > (CNT_W+1)'(MAX_SYMS)) ? CNT_W'(MAX_SYMS) : dct_count;

    nios2vga_dct_shift u_shift (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .shift    (shift),
        .load_buf (dct_buffer),
        .load_cnt (cnt_in),
        .sym      (sym),
        .rem      (rem)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            ending_flag <= 1'b0;
            sym_total   <= '0;
        end else begin
            state <= state_next;
            if (test_ending) begin
                ending_flag <= 1'b1;
            end
            if (hs_out) begin
                sym_total <= sym_total + TOTAL_W'(1);
            end
        end
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        shift      = 1'b0;
        in_ready   = 1'b0;
        hs_out     = (state == EMIT) && out_ready;
        case (state)
            IDLE: begin
                in_ready = !ending_flag;
                if (ending_flag) begin
                    state_next = ENDED;
                end else if (in_valid && (cnt_in != '0)) begin
                    load       = 1'b1;
                    state_next = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    shift = 1'b1;
                    if (rem == CNT_W'(1)) begin
                        // Last symbol leaving: refill in the same cycle to avoid a bubble.
                        in_ready = !ending_flag;
                        if (!ending_flag && in_valid && (cnt_in != '0)) begin
                            load = 1'b1;
                        end else begin
                            state_next = ending_flag ? ENDED : IDLE;
                        end
                    end
                end
            end
            ENDED: begin
            end
            default: state_next = IDLE;
        endcase
    end

    assign out_valid      = (state == EMIT);
    assign out_last       = (state == EMIT) && (rem == CNT_W'(1));
    assign out_symbol     = (state == EMIT) ? sym : '0;
    assign test_has_ended = (state == ENDED);

endmodule

// File: tb/tb_nios2vga_cpu_dct_unpacker.sv
// Directed bench for the trace-word unpacker: streaming, back-to-back, stalls, flush and reset.
module tb_nios2vga_cpu_dct_unpacker;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  out_symbol;
    logic        out_last;
    logic        out_valid;
    logic        out_ready;
    logic        test_ending;
    logic        test_has_ended;
    logic [15:0] sym_total;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    nios2vga_cpu_dct_unpacker dut (
        .clk            (clk),
        .reset          (reset),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .out_symbol     (out_symbol),
        .out_last       (out_last),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .test_ending    (test_ending),
        .test_has_ended (test_has_ended),
        .sym_total      (sym_total)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven here, outputs checked after settle.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_sym(input string tag, input logic [1:0] s, input logic last);
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_sym"}, out_symbol, s);
        chk({tag, "_last"}, out_last, last);
    endtask

    initial begin
        reset       = 1'b1;
        dct_buffer  = '0;
        dct_count   = '0;
        in_valid    = 1'b0;
        out_ready   = 1'b1;
        test_ending = 1'b0;
        cyc();
        cyc();
        settle();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_out_symbol", out_symbol, 2'd0);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_ended", test_has_ended, 1'b0);
        chk("rst_total", sym_total, 16'd0);

        // Full word of fifteen 2'b10 symbols
        reset      = 1'b0;
        dct_buffer = 30'h2AAAAAAA;
        dct_count  = 4'd15;
        in_valid   = 1'b1;
        settle();
        chk("w15_in_ready", in_ready, 1'b1);
        chk("w15_pre_valid", out_valid, 1'b0);
        cyc();
        in_valid = 1'b0;
        settle();
        for (int i = 0; i < 15; i++) begin
            chk_sym("w15", 2'd2, (i == 14));
            cyc();
            settle();
        end
        chk("w15_done_valid", out_valid, 1'b0);
        chk("w15_total", sym_total, 16'd15);
        chk("w15_in_ready_idle", in_ready, 1'b1);

        // Two words back to back: 3,2,1 then 2,3
        dct_buffer = 30'h0000001B;
        dct_count  = 4'd3;
        in_valid   = 1'b1;
        settle();
        cyc();
        dct_buffer = 30'h0000000E;
        dct_count  = 4'd2;
        settle();
        chk_sym("b2b_a0", 2'd3, 1'b0);
        chk("b2b_a0_in_ready", in_ready, 1'b0);
        cyc();
        settle();
        chk_sym("b2b_a1", 2'd2, 1'b0);
        cyc();
        settle();
        chk_sym("b2b_a2", 2'd1, 1'b1);
        chk("b2b_a2_in_ready", in_ready, 1'b1);
        cyc();
        in_valid = 1'b0;
        settle();
        chk_sym("b2b_b0", 2'd2, 1'b0);
        cyc();
        settle();
        chk_sym("b2b_b1", 2'd3, 1'b1);
        cyc();
        settle();
        chk("b2b_done_valid", out_valid, 1'b0);
        chk("b2b_total", sym_total, 16'd20);

        // Alternating stalls on a count=4 word: symbols 0,1,2,3
        dct_buffer = 30'h000000E4;
        dct_count  = 4'd4;
        in_valid   = 1'b1;
        settle();
        cyc();
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            out_ready = (k % 2 == 1);
            settle();
            chk_sym("stall", 2'(k / 2), (k / 2 == 3));
            cyc();
        end
        out_ready = 1'b1;
        settle();
        chk("stall_done_valid", out_valid, 1'b0);
        chk("stall_total", sym_total, 16'd24);

        // Empty word is swallowed silently
        dct_buffer = 30'h3FFFFFFF;
        dct_count  = 4'd0;
        in_valid   = 1'b1;
        settle();
        chk("zero_in_ready", in_ready, 1'b1);
        cyc();
        settle();
        chk("zero_valid", out_valid, 1'b0);
        chk("zero_in_ready2", in_ready, 1'b1);
        cyc();
        in_valid = 1'b0;
        settle();
        chk("zero_valid2", out_valid, 1'b0);
        chk("zero_total", sym_total, 16'd24);

        // End-of-trace raised mid-word: symbols 1,2,3,0,1
        dct_buffer = 30'h00000139;
        dct_count  = 4'd5;
        in_valid   = 1'b1;
        settle();
        cyc();
        in_valid = 1'b0;
        settle();
        chk_sym("end_s0", 2'd1, 1'b0);
        cyc();
        settle();
        chk_sym("end_s1", 2'd2, 1'b0);
        cyc();
        test_ending = 1'b1;
        settle();
        chk_sym("end_s2", 2'd3, 1'b0);
        cyc();
        test_ending = 1'b0;
        dct_buffer  = 30'h00000005;
        dct_count   = 4'd2;
        in_valid    = 1'b1;
        settle();
        chk_sym("end_s3", 2'd0, 1'b0);
        chk("end_in_ready_s3", in_ready, 1'b0);
        chk("end_not_yet", test_has_ended, 1'b0);
        cyc();
        settle();
        chk_sym("end_s4", 2'd1, 1'b1);
        chk("end_in_ready_s4", in_ready, 1'b0);
        cyc();
        settle();
        chk("end_ended", test_has_ended, 1'b1);
        chk("end_valid", out_valid, 1'b0);
        chk("end_in_ready", in_ready, 1'b0);
        chk("end_total", sym_total, 16'd29);
        for (int i = 0; i < 3; i++) begin
            cyc();
            settle();
            chk("end_hold", test_has_ended, 1'b1);
            chk("end_hold_valid", out_valid, 1'b0);
            chk("end_hold_total", sym_total, 16'd29);
        end

        // Reset interrupting a word
        reset    = 1'b1;
        in_valid = 1'b0;
        cyc();
        reset      = 1'b0;
        dct_buffer = 30'h000000E4;
        dct_count  = 4'd4;
        in_valid   = 1'b1;
        settle();
        chk("rst2_in_ready", in_ready, 1'b1);
        chk("rst2_ended_clear", test_has_ended, 1'b0);
        cyc();
        in_valid = 1'b0;
        settle();
        chk_sym("rst2_s0", 2'd0, 1'b0);
        cyc();
        reset = 1'b1;
        settle();
        chk_sym("rst2_s1", 2'd1, 1'b0);
        cyc();
        reset = 1'b0;
        settle();
        chk("rst2_valid", out_valid, 1'b0);
        chk("rst2_in_ready_after", in_ready, 1'b1);
        chk("rst2_total", sym_total, 16'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            settle();
            chk("rst2_no_resume", out_valid, 1'b0);
            chk("rst2_total_hold", sym_total, 16'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
